// File: rtl/rtc_timekeeper.sv
`default_nettype none
// ============================================================================
// Module      : rtc_timekeeper
// Description : 24-hour packed-BCD real-time clock. It counts one second per
//               tick strobe and accepts validated time loads. It produces
//               registered one-cycle rollover strobes and set accept/reject
//               strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module rtc_timekeeper #(
    parameter logic [7:0] INIT_HOURS   = 8'h00,
    parameter logic [7:0] INIT_MINUTES = 8'h00,
    parameter logic [7:0] INIT_SECONDS = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       set_valid,
    input  logic [7:0] set_hours,
    input  logic [7:0] set_minutes,
    input  logic [7:0] set_seconds,
    output logic [7:0] hours,
    output logic [7:0] minutes,
    output logic [7:0] seconds,
    output logic       set_ack,
    output logic       set_err,
    output logic       sec_pulse,
    output logic       min_pulse,
    output logic       hour_pulse,
    output logic       day_pulse
);

    // ------------------------------------------------------------------------
    // BCD helpers
    // ------------------------------------------------------------------------

    // Minutes/seconds field: tens 0-5, ones 0-9.
    function automatic logic is_legal_ms(input logic [7:0] v);
        return (v[7:4] <= 4'd5) && (v[3:0] <= 4'd9);
    endfunction

    // Hours field: 00-19 or 20-23.
    function automatic logic is_legal_hr(input logic [7:0] v);
        return ((v[7:4] <= 4'd1) && (v[3:0] <= 4'd9)) ||
               ((v[7:4] == 4'd2) && (v[3:0] <= 4'd3));
    endfunction

    // Packed-BCD increment that wraps to 00 after reaching max_val.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v,
                                           input logic [7:0] max_val);
        logic [7:0] r;
        if (v == max_val) begin
            r = 8'h00;
        end else if (v[3:0] == 4'd9) begin
            r = {v[7:4] + 4'd1, 4'd0};
        end else begin
            r = {v[7:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

    // Reset values. An out-of-range INIT field falls back to zero so the
    // counters always start from a legal time.
    localparam logic [7:0] c_init_hours   = is_legal_hr(INIT_HOURS)   ? INIT_HOURS   : 8'h00;
    localparam logic [7:0] c_init_minutes = is_legal_ms(INIT_MINUTES) ? INIT_MINUTES : 8'h00;
    localparam logic [7:0] c_init_seconds = is_legal_ms(INIT_SECONDS) ? INIT_SECONDS : 8'h00;

    localparam logic [7:0] c_max_hours = 8'h23;
    localparam logic [7:0] c_max_ms    = 8'h59;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [7:0] hours_q,   hours_d;
    logic [7:0] minutes_q, minutes_d;
    logic [7:0] seconds_q, seconds_d;
    logic       set_ack_q, set_ack_d;
    logic       set_err_q, set_err_d;
    logic       sec_pulse_q,  sec_pulse_d;
    logic       min_pulse_q,  min_pulse_d;
    logic       hour_pulse_q, hour_pulse_d;
    logic       day_pulse_q,  day_pulse_d;

    // ------------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------------
    logic w_set_legal;
    logic w_set_accept;
    logic w_set_reject;
    logic w_count;
    logic w_sec_wrap;
    logic w_min_wrap;
    logic w_hour_wrap;

    // Classify the load request. An accepted load takes priority and swallows
    // any tick in the same cycle. A rejected load leaves the tick untouched.
    always_comb begin
        w_set_legal  = is_legal_hr(set_hours)   &&
                       is_legal_ms(set_minutes) &&
                       is_legal_ms(set_seconds);
        w_set_accept = set_valid &&  w_set_legal;
        w_set_reject = set_valid && !w_set_legal;
        w_count      = tick && !w_set_accept;
        w_sec_wrap   = (seconds_q == c_max_ms);
        w_min_wrap   = (minutes_q == c_max_ms);
        w_hour_wrap  = (hours_q   == c_max_hours);
    end

    // ------------------------------------------------------------------------
    // Next-state time and strobe computation
    // ------------------------------------------------------------------------

    // Advance the time on a counted tick, cascading carries within the same
    // edge. Otherwise, load the time or hold it.
    always_comb begin
        hours_d   = hours_q;
        minutes_d = minutes_q;
        seconds_d = seconds_q;
        if (w_set_accept) begin
            hours_d   = set_hours;
            minutes_d = set_minutes;
            seconds_d = set_seconds;
        end else if (w_count) begin
            seconds_d = bcd_inc(seconds_q, c_max_ms);
            if (w_sec_wrap) begin
                minutes_d = bcd_inc(minutes_q, c_max_ms);
                if (w_min_wrap) begin
                    hours_d = bcd_inc(hours_q, c_max_hours);
                end
            end
        end
    end

    // Rollover strobes follow the carry chain only. A load never raises them.
    always_comb begin
        sec_pulse_d  = w_count;
        min_pulse_d  = w_count && w_sec_wrap;
        hour_pulse_d = w_count && w_sec_wrap && w_min_wrap;
        day_pulse_d  = w_count && w_sec_wrap && w_min_wrap && w_hour_wrap;
        set_ack_d    = w_set_accept;
        set_err_d    = w_set_reject;
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------

    // Synchronous reset overrides any tick or load on the same edge and
    // clears every strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            hours_q      <= c_init_hours;
            minutes_q    <= c_init_minutes;
            seconds_q    <= c_init_seconds;
            set_ack_q    <= 1'b0;
            set_err_q    <= 1'b0;
            sec_pulse_q  <= 1'b0;
            min_pulse_q  <= 1'b0;
            hour_pulse_q <= 1'b0;
            day_pulse_q  <= 1'b0;
        end else begin
            hours_q      <= hours_d;
            minutes_q    <= minutes_d;
            seconds_q    <= seconds_d;
            set_ack_q    <= set_ack_d;
            set_err_q    <= set_err_d;
            sec_pulse_q  <= sec_pulse_d;
            min_pulse_q  <= min_pulse_d;
            hour_pulse_q <= hour_pulse_d;
            day_pulse_q  <= day_pulse_d;
        end
    end

    // All outputs come straight from flops.
    assign hours      = hours_q;
    assign minutes    = minutes_q;
    assign seconds    = seconds_q;
    assign set_ack    = set_ack_q;
    assign set_err    = set_err_q;
    assign sec_pulse  = sec_pulse_q;
    assign min_pulse  = min_pulse_q;
    assign hour_pulse = hour_pulse_q;
    assign day_pulse  = day_pulse_q;

endmodule
`default_nettype wire

// File: tb/tb_rtc_timekeeper.sv
`default_nettype none
// ============================================================================
// Module      : tb_rtc_timekeeper
// Description : Self-checking scoreboard bench for rtc_timekeeper.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rtc_timekeeper;

    typedef struct packed {
        logic       r;
        logic       tk;
        logic       sv;
        logic [7:0] h;
        logic [7:0] m;
        logic [7:0] s;
    } stim_t;

    logic       clk = 1'b0;
    logic       rst, tick, set_valid;
    logic [7:0] set_hours, set_minutes, set_seconds;
    logic [7:0] hours, minutes, seconds;
    logic       set_ack, set_err, sec_pulse, min_pulse, hour_pulse, day_pulse;
    logic [7:0] b_hours, b_minutes, b_seconds;
    logic       b_ack, b_err, b_sp, b_mp, b_hp, b_dp;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [29:0] sb[$];
    int         m_time;

    always #5 clk = ~clk;

    rtc_timekeeper dut (
        .clk(clk), .rst(rst), .tick(tick), .set_valid(set_valid),
        .set_hours(set_hours), .set_minutes(set_minutes), .set_seconds(set_seconds),
        .hours(hours), .minutes(minutes), .seconds(seconds),
        .set_ack(set_ack), .set_err(set_err),
        .sec_pulse(sec_pulse), .min_pulse(min_pulse),
        .hour_pulse(hour_pulse), .day_pulse(day_pulse)
    );

    // Second instance with partly illegal INIT values
    rtc_timekeeper #(
        .INIT_HOURS(8'h24), .INIT_MINUTES(8'h07), .INIT_SECONDS(8'h5B)
    ) dut_init (
        .clk(clk), .rst(rst), .tick(tick), .set_valid(set_valid),
        .set_hours(set_hours), .set_minutes(set_minutes), .set_seconds(set_seconds),
        .hours(b_hours), .minutes(b_minutes), .seconds(b_seconds),
        .set_ack(b_ack), .set_err(b_err),
        .sec_pulse(b_sp), .min_pulse(b_mp), .hour_pulse(b_hp), .day_pulse(b_dp)
    );

    function automatic logic [7:0] to_bcd(input int n);
        logic [3:0] t, o;
        t = 4'(n / 10);
        o = 4'(n % 10);
        return {t, o};
    endfunction

    function automatic bit field_ok(input logic [7:0] v, input int lim);
        int t, o;
        t = int'(v[7:4]);
        o = int'(v[3:0]);
        return (t < 10) && (o < 10) && (t * 10 + o <= lim);
    endfunction

    function automatic int field_val(input logic [7:0] v);
        return int'(v[7:4]) * 10 + int'(v[3:0]);
    endfunction

    function automatic logic [29:0] observed();
        return {hours, minutes, seconds, set_ack, set_err,
                sec_pulse, min_pulse, hour_pulse, day_pulse};
    endfunction

    function automatic string fmt(input logic [29:0] v);
        return $sformatf("%h:%h:%h ack=%b err=%b s/m/h/d=%b%b%b%b",
                         v[29:22], v[21:14], v[13:6], v[5], v[4],
                         v[3], v[2], v[1], v[0]);
    endfunction

    // Drive one cycle of stimulus, advance the reference model and queue
    // the outputs expected after this edge.
    task automatic apply(input stim_t st);
        bit acc, rej, sp, mp, hp, dp;
        int hh, mm, ss;
        rst = st.r; tick = st.tk; set_valid = st.sv;
        set_hours = st.h; set_minutes = st.m; set_seconds = st.s;
        acc = 0; rej = 0; sp = 0; mp = 0; hp = 0; dp = 0;
        if (st.r) begin
            m_time = 0;
        end else begin
            if (st.sv) begin
                if (field_ok(st.h, 23) && field_ok(st.m, 59) && field_ok(st.s, 59)) acc = 1;
                else rej = 1;
            end
            if (acc) begin
                m_time = field_val(st.h) * 3600 + field_val(st.m) * 60 + field_val(st.s);
            end else if (st.tk) begin
                sp = 1;
                mp = (m_time % 60) == 59;
                hp = (m_time % 3600) == 3599;
                dp = m_time == 86399;
                m_time = (m_time + 1) % 86400;
            end
        end
        hh = m_time / 3600;
        mm = (m_time / 60) % 60;
        ss = m_time % 60;
        sb.push_back({to_bcd(hh), to_bcd(mm), to_bcd(ss), acc, rej, sp, mp, hp, dp});
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        stim_t seq[$];
        logic [29:0] exp;
        // reset collides with tick and an otherwise legal set
        seq.push_back({1'b1, 1'b1, 1'b1, 8'h12, 8'h34, 8'h56});
        for (int i = 0; i < 5; i++) seq.push_back({1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00});
        foreach (seq[i]) begin
            apply(seq[i]);
            exp = sb.pop_front();
            n_checks++;
            if (observed() !== exp) begin
                n_fail++;
                $display("FAIL reset[%0d]: got %s, expected %s", i, fmt(observed()), fmt(exp));
            end
            if (i == 0) begin
                n_checks++;
                if ({b_hours, b_minutes, b_seconds, b_ack, b_err, b_sp, b_mp, b_hp, b_dp}
                    !== {8'h00, 8'h07, 8'h00, 6'b0}) begin
                    n_fail++;
                    $display("FAIL init_sanitize: got %h:%h:%h flags=%b%b%b%b%b%b, expected 00:07:00 flags=000000",
                             b_hours, b_minutes, b_seconds, b_ack, b_err, b_sp, b_mp, b_hp, b_dp);
                end
            end
        end
    endtask

    task automatic test_day_rollover();
        stim_t seq[$];
        logic [29:0] exp;
        seq.push_back({1'b0, 1'b0, 1'b1, 8'h23, 8'h59, 8'h58});
        seq.push_back({1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00});
        seq.push_back({1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00});
        seq.push_back({1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00});
        foreach (seq[i]) begin
            apply(seq[i]);
            exp = sb.pop_front();
            n_checks++;
            if (observed() !== exp) begin
                n_fail++;
                $display("FAIL day_rollover[%0d]: got %s, expected %s", i, fmt(observed()), fmt(exp));
            end
        end
    endtask

    task automatic test_bcd_carry();
        stim_t seq[$];
        logic [29:0] exp;
        seq.push_back({1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h09});
        seq.push_back({1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00});
        seq.push_back({1'b0, 1'b0, 1'b1, 8'h00, 8'h09, 8'h59});
        seq.push_back({1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00});
        seq.push_back({1'b0, 1'b0, 1'b1, 8'h09, 8'h59, 8'h59});
        seq.push_back({1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00});
        seq.push_back({1'b0, 1'b0, 1'b1, 8'h19, 8'h59, 8'h59});
        seq.push_back({1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00});
        foreach (seq[i]) begin
            apply(seq[i]);
            exp = sb.pop_front();
            n_checks++;
            if (observed() !== exp) begin
                n_fail++;
                $display("FAIL bcd_carry[%0d]: got %s, expected %s", i, fmt(observed()), fmt(exp));
            end
        end
    endtask

    task automatic test_illegal_set();
        stim_t seq[$];
        logic [29:0] exp;
        seq.push_back({1'b0, 1'b0, 1'b1, 8'h10, 8'h20, 8'h30});
        seq.push_back({1'b0, 1'b0, 1'b1, 8'h11, 8'h22, 8'h5A});
        seq.push_back({1'b0, 1'b0, 1'b1, 8'h11, 8'h22, 8'h60});
        seq.push_back({1'b0, 1'b0, 1'b1, 8'h24, 8'h22, 8'h33});
        seq.push_back({1'b0, 1'b1, 1'b1, 8'h1A, 8'h00, 8'h00});
        seq.push_back({1'b0, 1'b1, 1'b1, 8'h05, 8'h60, 8'h00});
        seq.push_back({1'b0, 1'b0, 1'b1, 8'h10, 8'h20, 8'h59});
        seq.push_back({1'b0, 1'b1, 1'b1, 8'h05, 8'h0F, 8'h00});
        foreach (seq[i]) begin
            apply(seq[i]);
            exp = sb.pop_front();
            n_checks++;
            if (observed() !== exp) begin
                n_fail++;
                $display("FAIL illegal_set[%0d]: got %s, expected %s", i, fmt(observed()), fmt(exp));
            end
        end
    endtask

    task automatic test_set_with_tick();
        stim_t seq[$];
        logic [29:0] exp;
        seq.push_back({1'b0, 1'b1, 1'b1, 8'h12, 8'h34, 8'h56});
        seq.push_back({1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 8'h00});
        seq.push_back({1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00});
        foreach (seq[i]) begin
            apply(seq[i]);
            exp = sb.pop_front();
            n_checks++;
            if (observed() !== exp) begin
                n_fail++;
                $display("FAIL set_with_tick[%0d]: got %s, expected %s", i, fmt(observed()), fmt(exp));
            end
        end
    endtask

    task automatic test_reset_mid();
        stim_t seq[$];
        logic [29:0] exp;
        seq.push_back({1'b0, 1'b0, 1'b1, 8'h23, 8'h59, 8'h58});
        seq.push_back({1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00});
        seq.push_back({1'b1, 1'b1, 1'b1, 8'h01, 8'h02, 8'h03});
        seq.push_back({1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00});
        foreach (seq[i]) begin
            apply(seq[i]);
            exp = sb.pop_front();
            n_checks++;
            if (observed() !== exp) begin
                n_fail++;
                $display("FAIL reset_mid[%0d]: got %s, expected %s", i, fmt(observed()), fmt(exp));
            end
        end
    endtask

    task automatic test_back_to_back();
        stim_t st;
        logic [29:0] exp;
        int sec_cnt;
        sec_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            apply({1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00});
            exp = sb.pop_front();
            n_checks++;
            if (observed() !== exp) begin
                n_fail++;
                $display("FAIL back_to_back[%0d]: got %s, expected %s", i, fmt(observed()), fmt(exp));
            end
            if (sec_pulse === 1'b1) sec_cnt++;
        end
        n_checks++;
        if (sec_cnt != 3 || seconds !== 8'h03) begin
            n_fail++;
            $display("FAIL back_to_back_total: got %0d sec pulses sec=%h, expected 3 pulses sec=03",
                     sec_cnt, seconds);
        end
        // randomised mix of ticks, legal loads and illegal loads
        for (int i = 0; i < 400; i++) begin
            st.r  = ($urandom_range(0, 99) == 0);
            st.tk = $urandom_range(0, 2) != 0;
            st.sv = $urandom_range(0, 5) == 0;
            if ($urandom_range(0, 3) != 0) begin
                st.h = to_bcd($urandom_range(0, 23));
                st.m = to_bcd(($urandom_range(0, 1) == 0) ? 59 : $urandom_range(0, 59));
                st.s = to_bcd($urandom_range(50, 59));
            end else begin
                st.h = 8'($urandom);
                st.m = 8'($urandom);
                st.s = 8'($urandom);
            end
            apply(st);
            exp = sb.pop_front();
            n_checks++;
            if (observed() !== exp) begin
                n_fail++;
                $display("FAIL random[%0d]: got %s, expected %s", i, fmt(observed()), fmt(exp));
            end
        end
    endtask

    initial begin
        rst = 1'b1; tick = 1'b0; set_valid = 1'b0;
        set_hours = 8'h00; set_minutes = 8'h00; set_seconds = 8'h00;
        m_time = 0;
        test_reset();
        test_day_rollover();
        test_bcd_carry();
        test_illegal_set();
        test_set_with_tick();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rtc_timekeeper.md
RTC_TIMEKEEPER -- requirements
Module: rtc_timekeeper

Interface
REQ-001 Parameter INIT_HOURS, default 8'h00, packed-BCD hours value loaded at reset.
REQ-002 Parameter INIT_MINUTES, default 8'h00, packed-BCD minutes value loaded at reset.
REQ-003 Parameter INIT_SECONDS, default 8'h00, packed-BCD seconds value loaded at reset.
REQ-004 clk  input  1  system clock; all state SHALL update on rising edge only.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 tick  input  1  one-cycle 1 Hz strobe from the upstream divider; each cycle high SHALL count as one second.
REQ-007 set_valid  input  1  one-cycle request to load time from set_* inputs.
REQ-008 set_hours / set_minutes / set_seconds  input  8 each  packed-BCD load value, sampled only when set_valid=1.
REQ-009 hours / minutes / seconds  output  8 each  registered packed-BCD current time, 24 h format.
REQ-010 set_ack  output  1  one-cycle pulse: load accepted.
REQ-011 set_err  output  1  one-cycle pulse: load rejected.
REQ-012 sec_pulse / min_pulse / hour_pulse / day_pulse  output  1 each  one-cycle registered rollover strobes.

Function
REQ-013 Legal values: each nibble 0-9; seconds and minutes 00-59; hours 00-23.
REQ-014 Tick with no accepted set: seconds SHALL increment in BCD on the clock edge sampling tick; result visible the following cycle (latency 1).
REQ-015 BCD increment: ones nibble 9 -> 0 with tens+1; never produce A-F nibbles.
REQ-016 seconds 59 -> 00 SHALL increment minutes in the same edge; minutes 59 -> 00 SHALL increment hours in the same edge; hours 23 -> 00 wraps.
REQ-017 sec_pulse=1 for the cycle after every counted tick; min_pulse when minutes change by carry; hour_pulse when hours change by carry; day_pulse when 23:59:59 -> 00:00:00; all simultaneous pulses SHALL assert in the same cycle.
REQ-018 All pulse outputs SHALL be 0 in every cycle not specified above.
REQ-019 set_valid=1 with all three set_* values legal: hours/minutes/seconds SHALL take set values on that edge, set_ack=1 the next cycle, set_err=0.
REQ-020 set_valid=1 with any set_* value illegal: time SHALL remain unchanged by the set, set_err=1 the next cycle, set_ack=0.
REQ-021 Accepted set and tick in the same cycle: set wins; tick dropped; no rollover pulses asserted.
REQ-022 Rejected set and tick in the same cycle: tick SHALL be processed normally per REQ-014..017.
REQ-023 Loading a value SHALL NOT generate any rollover pulse, including load of 00:00:00.
REQ-024 Consecutive-cycle ticks or set requests SHALL each be processed independently; no internal busy state; no back-pressure.
REQ-025 Block SHALL be a registered datapath with no combinational path from any input to any output.

Reset
REQ-026 rst=1 on an edge: hours/minutes/seconds = INIT_HOURS/INIT_MINUTES/INIT_SECONDS; set_ack, set_err, and all pulses = 0.
REQ-027 rst SHALL take priority over tick and set_valid in the same cycle; both are discarded.
REQ-028 Any INIT_* parameter illegal per REQ-013: that field SHALL reset to 8'h00.
REQ-029 rst mid-operation (e.g. in the cycle after a tick) SHALL suppress any pending pulse; the cycle after reset shows reset values only.

Verification
REQ-030 rst 1 cycle, defaults -> 00:00:00; all pulses, set_ack, and set_err 0; ticks held 0 for 5 cycles -> time unchanged.
REQ-031 set 23:59:58 -> set_ack=1 next cycle; tick -> 23:59:59, sec_pulse only; tick -> 00:00:00 with sec/min/hour/day_pulse all 1 in the same cycle.
REQ-032 Start 00:00:09, tick -> 00:00:10, sec_pulse=1, min_pulse=0; start 00:09:59, tick -> 00:10:00, sec_pulse=1, min_pulse=1.
REQ-033 set_seconds=8'h5A (or 8'h60, or hours 8'h24) -> set_err=1, set_ack=0, time unchanged; with tick in the same cycle -> time advanced by 1 s.
REQ-034 set 12:34:56 with tick in the same cycle -> 12:34:56, set_ack=1, sec_pulse=0.
REQ-035 rst with tick and set_valid in the same cycle -> INIT values, no ack/err/pulses; ticks on 3 consecutive cycles -> +3 s, 3 sec_pulse cycles.
